// File: rtl/smvm_stream_if.sv
// smvm_stream_if: nonzero-beat input stream and row-result output stream of smvm_stream.
interface smvm_stream_if #(
    parameter int K     = 4,
    parameter int VAL_W = 8,
    parameter int IDX_W = 9,
    parameter int ACC_W = 20,
    parameter int ROW_W = 9
);
    logic               nz_valid;
    logic               nz_ready;
    logic [K-1:0]       nz_lane_en;
    logic [K*VAL_W-1:0] nz_val;
    logic [K*IDX_W-1:0] nz_col;
    logic [K-1:0]       nz_eor;
    logic               out_valid;
    logic               out_ready;
    logic [ACC_W-1:0]   out_data;
    logic [ROW_W-1:0]   out_row;

    modport master (
        output nz_valid, nz_lane_en, nz_val, nz_col, nz_eor, out_ready,
        input  nz_ready, out_valid, out_data, out_row
    );
    modport slave (
        input  nz_valid, nz_lane_en, nz_val, nz_col, nz_eor, out_ready,
        output nz_ready, out_valid, out_data, out_row
    );
endinterface

// File: rtl/smvm_stream.sv
// smvm_stream: streaming sparse matrix x dense vector, K nonzeros per beat, row results via FIFO.
module smvm_stream #(
    parameter int K          = 4,
    parameter int VAL_W      = 8,
    parameter int VEC_DEPTH  = 512,
    parameter int IDX_W      = 9,
    parameter int ACC_W      = 20,
    parameter int ROW_W      = 9,
    parameter int FIFO_DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vec_wr_en,
    input  logic [IDX_W-1:0] vec_wr_addr,
    input  logic [VAL_W-1:0] vec_wr_data,
    input  logic             start,
    input  logic [ROW_W-1:0] cfg_rows,
    smvm_stream_if.slave     s,
    output logic             done,
    output logic             err
);
    localparam int VW = $clog2(VEC_DEPTH);
    localparam int PW = 2 * VAL_W;
    localparam int CW = $clog2(K + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FIFO_DEPTH + 1) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    state_t state, state_n;

    logic [VAL_W-1:0]        vec [VEC_DEPTH];
    logic [ROW_W-1:0]        rows_r, row_idx;
    logic signed [ACC_W-1:0] carry;
    logic                    s1_valid;
    logic [K-1:0]            s1_en, s1_eor;
    logic signed [PW-1:0]    s1_prod [K];
    logic [CW-1:0]           s2_cnt;
    logic [ACC_W-1:0]        s2_data [K];
    logic [ROW_W-1:0]        s2_row [K];
    logic [ACC_W-1:0]        f_data [FIFO_DEPTH];
    logic [ROW_W-1:0]        f_row [FIFO_DEPTH];
    logic [AW-1:0]           rd_ptr, wr_ptr;
    logic [FW-1:0]           f_cnt, used;

    logic                    go, xfer, pop, drop;
    logic [K-1:0]            oob, push;
    logic [IDX_W-1:0]        col [K];
    logic signed [PW-1:0]    prod_n [K];
    logic signed [ACC_W-1:0] sum, lane_sum [K];
    logic [ROW_W:0]          lane_row [K];
    logic [CW-1:0]           pre [K];
    logic [CW-1:0]           n_eor, n_push;
    logic [ACC_W-1:0]        s2_data_n [K];
    logic [ROW_W-1:0]        s2_row_n [K];
    logic [AW-1:0]           waddr [K];

    assign go          = state == IDLE && start;
    assign xfer        = s.nz_valid && s.nz_ready;
    assign pop         = s.out_valid && s.out_ready;
    // Every result already committed downstream of the input counts against FIFO space.
    assign used        = f_cnt + FW'(s2_cnt) + FW'($countones(s1_eor));
    assign s.out_valid = f_cnt != '0;
    assign s.out_data  = f_data[rd_ptr];
    assign s.out_row   = f_row[rd_ptr];

    always_comb begin
        state_n    = state;
        done       = 1'b0;
        s.nz_ready = 1'b0;
        if (go) state_n = RUN;
        if (state == RUN) begin
            s.nz_ready = used <= FW'(FIFO_DEPTH - 2 * K);
            if (row_idx == rows_r) state_n = FLUSH;
        end
        if (state == FLUSH && f_cnt == '0 && !s1_valid && s2_cnt == '0) begin
            state_n = IDLE;
            done    = 1'b1;
        end
    end

    always_comb begin
        oob = '0;
        for (int i = 0; i < K; i++) begin
            col[i]    = s.nz_col[i*IDX_W +: IDX_W];
            oob[i]    = s.nz_lane_en[i] && int'(col[i]) >= VEC_DEPTH;
            prod_n[i] = '0;
            if (s.nz_lane_en[i] && !oob[i])
                prod_n[i] = $signed(s.nz_val[i*VAL_W +: VAL_W]) * $signed(vec[col[i][VW-1:0]]);
        end
    end

    // Segmented reduction: eor lanes close a row; rows beyond cfg_rows are dropped.
    always_comb begin
        sum    = carry;
        n_eor  = '0;
        n_push = '0;
        drop   = 1'b0;
        push   = '0;
        for (int i = 0; i < K; i++) begin
            if (s1_en[i]) sum = sum + ACC_W'(s1_prod[i]);
            lane_sum[i] = sum;
            pre[i]      = n_eor;
            lane_row[i] = {1'b0, row_idx} + (ROW_W+1)'(n_eor);
            push[i]     = s1_eor[i] && lane_row[i] < {1'b0, rows_r};
            drop        = drop | (s1_eor[i] && !push[i]);
            n_push      = n_push + CW'(push[i]);
            if (s1_eor[i]) begin
                n_eor = n_eor + CW'(1);
                sum   = '0;
            end
        end
        for (int j = 0; j < K; j++) begin
            s2_data_n[j] = '0;
            s2_row_n[j]  = '0;
            waddr[j]     = AW'((int'(wr_ptr) + j) % FIFO_DEPTH);
            for (int i = 0; i < K; i++)
                if (push[i] && pre[i] == CW'(j)) begin
                    s2_data_n[j] = lane_sum[i];
                    s2_row_n[j]  = lane_row[i][ROW_W-1:0];
                end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rows_r   <= '0;
            row_idx  <= '0;
            carry    <= '0;
            err      <= 1'b0;
            s1_valid <= 1'b0;
            s1_en    <= '0;
            s1_eor   <= '0;
            s2_cnt   <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            f_cnt    <= '0;
            for (int i = 0; i < VEC_DEPTH; i++) vec[i] <= '0;
            for (int i = 0; i < K; i++) begin
                s1_prod[i] <= '0;
                s2_data[i] <= '0;
                s2_row[i]  <= '0;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                f_data[i] <= '0;
                f_row[i]  <= '0;
            end
        end else begin
            state <= state_n;
            if (state == IDLE && vec_wr_en && int'(vec_wr_addr) < VEC_DEPTH)
                vec[vec_wr_addr[VW-1:0]] <= vec_wr_data;
            s1_valid <= xfer;
            s1_en    <= xfer ? s.nz_lane_en : '0;
            s1_eor   <= xfer ? s.nz_eor & s.nz_lane_en : '0;
            s2_cnt   <= n_push;
            for (int i = 0; i < K; i++) begin
                s1_prod[i] <= prod_n[i];
                s2_data[i] <= s2_data_n[i];
                s2_row[i]  <= s2_row_n[i];
                if (CW'(i) < s2_cnt) begin
                    f_data[waddr[i]] <= s2_data[i];
                    f_row[waddr[i]]  <= s2_row[i];
                end
            end
            wr_ptr  <= AW'((int'(wr_ptr) + int'(s2_cnt)) % FIFO_DEPTH);
            rd_ptr  <= pop ? AW'((int'(rd_ptr) + 1) % FIFO_DEPTH) : rd_ptr;
            f_cnt   <= f_cnt + FW'(s2_cnt) - FW'(pop);
            carry   <= go ? '0 : sum;
            row_idx <= go ? '0 : row_idx + ROW_W'(n_push);
            rows_r  <= go ? cfg_rows : rows_r;
            err     <= go ? 1'b0 : err | drop | (xfer && |oob);
        end
    end
endmodule

// File: tb/tb_smvm_stream.sv
// tb_smvm_stream: directed beats with hand-computed row results, checked by a scoreboard monitor.
module tb_smvm_stream;
    localparam int K = 4, VAL_W = 8, VEC_DEPTH = 512, IDX_W = 10, ACC_W = 20, ROW_W = 9, FIFO_DEPTH = 16;

    typedef struct {
        logic [ACC_W-1:0] data;
        logic [ROW_W-1:0] row;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             vec_wr_en = 1'b0;
    logic [IDX_W-1:0] vec_wr_addr = '0;
    logic [VAL_W-1:0] vec_wr_data = '0;
    logic             start = 1'b0;
    logic [ROW_W-1:0] cfg_rows = '0;
    logic             done, err;
    int               checks = 0;
    int               failures = 0;
    exp_t             sb[$];
    exp_t             e;

    smvm_stream_if #(.K(K), .VAL_W(VAL_W), .IDX_W(IDX_W), .ACC_W(ACC_W), .ROW_W(ROW_W)) bus ();

    smvm_stream #(
        .K(K), .VAL_W(VAL_W), .VEC_DEPTH(VEC_DEPTH), .IDX_W(IDX_W),
        .ACC_W(ACC_W), .ROW_W(ROW_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .vec_wr_en(vec_wr_en), .vec_wr_addr(vec_wr_addr),
        .vec_wr_data(vec_wr_data), .start(start), .cfg_rows(cfg_rows),
        .s(bus), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected got data=%0h row=%0d exp no result", bus.out_data, bus.out_row);
            end else begin
                e = sb.pop_front();
                if (bus.out_data !== e.data || bus.out_row !== e.row) begin
                    failures++;
                    $display("FAIL sb_result got data=%0h row=%0d exp data=%0h row=%0d",
                             bus.out_data, bus.out_row, e.data, e.row);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic push_exp(input int d, input int r);
        sb.push_back('{ACC_W'(d), ROW_W'(r)});
    endtask

    task automatic wr_vec(input int a, input int d);
        vec_wr_en   = 1'b1;
        vec_wr_addr = IDX_W'(a);
        vec_wr_data = VAL_W'(d);
        tick();
        vec_wr_en = 1'b0;
    endtask

    task automatic run(input int rows);
        start    = 1'b1;
        cfg_rows = ROW_W'(rows);
        tick();
        start = 1'b0;
    endtask

    task automatic set_beat(input logic [K-1:0] en, input logic [K*VAL_W-1:0] val,
                            input logic [K*IDX_W-1:0] col, input logic [K-1:0] eor);
        bus.nz_lane_en = en;
        bus.nz_val     = val;
        bus.nz_col     = col;
        bus.nz_eor     = eor;
        bus.nz_valid   = 1'b1;
    endtask

    task automatic send_beat(input logic [K-1:0] en, input logic [K*VAL_W-1:0] val,
                             input logic [K*IDX_W-1:0] col, input logic [K-1:0] eor);
        int n = 0;
        set_beat(en, val, col, eor);
        while (!bus.nz_ready && n < 200) begin
            tick();
            n++;
        end
        chk("beat_accept", 32'(bus.nz_ready), 1);
        tick();
        bus.nz_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(done), 1);
        tick();
    endtask

    initial begin
        int xfers;
        logic hs;
        bus.nz_valid   = 1'b0;
        bus.nz_lane_en = '0;
        bus.nz_val     = '0;
        bus.nz_col     = '0;
        bus.nz_eor     = '0;
        bus.out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_nz_ready", 32'(bus.nz_ready), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_data", 32'(bus.out_data), 0);
        chk("rst_done_err", {30'd0, done, err}, 0);
        rst = 1'b0;
        tick();

        // Four-lane dot product, first-result latency
        for (int i = 0; i < 4; i++) wr_vec(i, i + 1);
        run(1);
        push_exp(10, 0);
        send_beat(4'b1111, {4{8'd1}}, {10'd3, 10'd2, 10'd1, 10'd0}, 4'b1000);
        chk("lat_t0", 32'(bus.out_valid), 0);
        tick();
        chk("lat_t1", 32'(bus.out_valid), 0);
        tick();
        chk("lat_t2", 32'(bus.out_valid), 1);
        wait_done("a_done", 20);
        chk("a_err", 32'(err), 0);

        // Two rows in one beat; disabled lane carries a stray eor
        wr_vec(5, -3);
        run(2);
        push_exp(-6, 0);
        push_exp(-12, 1);
        send_beat(4'b0011, {8'd0, 8'd99, 8'd4, 8'd2}, {10'd0, 10'd0, 10'd5, 10'd5}, 4'b0111);
        wait_done("b_done", 20);
        chk("b_err", 32'(err), 0);

        // Row spanning two beats
        wr_vec(0, 7);
        run(1);
        push_exp(35, 0);
        send_beat(4'b1111, {4{8'd1}}, {4{10'd0}}, 4'b0000);
        send_beat(4'b0001, {8'd0, 8'd0, 8'd0, 8'd1}, {4{10'd0}}, 4'b0001);
        wait_done("c_done", 20);

        // Mixed rows with carry across beats
        run(3);
        push_exp(2, 0);
        push_exp(10, 1);
        push_exp(28, 2);
        send_beat(4'b1111, {8'd4, 8'd3, 8'd2, 8'd1}, {4{10'd1}}, 4'b0101);
        send_beat(4'b0001, {8'd0, 8'd0, 8'd0, 8'd5}, {10'd0, 10'd0, 10'd0, 10'd3}, 4'b0001);
        wait_done("d_done", 20);

        // 32 products of 16384 wrap to -2^19
        wr_vec(6, -128);
        run(1);
        push_exp(-524288, 0);
        for (int b = 0; b < 8; b++)
            send_beat(4'b1111, {4{8'h80}}, {4{10'd6}}, (b == 7) ? 4'b1000 : 4'b0000);
        wait_done("w_done", 30);

        // Extra eor past cfg_rows is dropped and flags err
        run(1);
        push_exp(7, 0);
        send_beat(4'b0011, {8'd0, 8'd0, 8'd1, 8'd1}, {4{10'd0}}, 4'b0011);
        wait_done("e_done", 20);
        chk("e_err", 32'(err), 1);

        // Out-of-range column
        run(1);
        chk("f_err_start_clr", 32'(err), 0);
        push_exp(2, 0);
        send_beat(4'b0011, {8'd0, 8'd0, 8'd1, 8'd5}, {10'd0, 10'd0, 10'd1, 10'd600}, 4'b0010);
        wait_done("f_done", 20);
        chk("f_err", 32'(err), 1);
        run(0);
        chk("f_err_clr", 32'(err), 0);
        wait_done("f0_done", 20);

        // Backpressure: three beats of four results fit, then stall
        bus.out_ready = 1'b0;
        run(40);
        xfers = 0;
        for (int c = 0; c < 12; c++) begin
            set_beat(4'b1111, {8'(4*xfers+4), 8'(4*xfers+3), 8'(4*xfers+2), 8'(4*xfers+1)},
                     {4{10'd1}}, 4'b1111);
            hs = bus.nz_ready;
            tick();
            if (hs) begin
                for (int i = 0; i < 4; i++) push_exp(2 * (4*xfers + i + 1), 4*xfers + i);
                xfers++;
            end
        end
        bus.nz_valid = 1'b0;
        chk("g_xfers", 32'(xfers), 3);
        chk("g_stall_ready", 32'(bus.nz_ready), 0);
        chk("g_head_data", 32'(bus.out_data), 2);
        start    = 1'b1;
        cfg_rows = '0;
        tick();
        start = 1'b0;
        wr_vec(1, 50);
        tick();
        chk("g_hold_data", 32'(bus.out_data), 2);
        chk("g_hold_row", 32'(bus.out_row), 0);
        bus.out_ready = 1'b1;
        for (int b = 3; b < 10; b++) begin
            for (int i = 0; i < 4; i++) push_exp(2 * (4*b + i + 1), 4*b + i);
            send_beat(4'b1111, {8'(4*b+4), 8'(4*b+3), 8'(4*b+2), 8'(4*b+1)}, {4{10'd1}}, 4'b1111);
        end
        wait_done("g_done", 200);
        chk("g_err", 32'(err), 0);
        chk("g_drained", 32'(sb.size()), 0);

        // Reset mid-run with three results queued
        bus.out_ready = 1'b0;
        run(5);
        send_beat(4'b0111, {4{8'd1}}, {4{10'd1}}, 4'b0111);
        repeat (3) tick();
        chk("h_queued", 32'(bus.out_valid), 1);
        rst = 1'b1;
        #1;
        chk("h_rst_valid", 32'(bus.out_valid), 0);
        chk("h_rst_ready", 32'(bus.nz_ready), 0);
        chk("h_rst_data", 32'(bus.out_data), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        chk("h_post_valid", 32'(bus.out_valid), 0);
        run(0);
        chk("h_done_run", 32'(done), 0);
        tick();
        chk("h_done_flush", 32'(done), 1);
        tick();
        run(1);
        push_exp(0, 0);
        send_beat(4'b0001, {8'd0, 8'd0, 8'd0, 8'd5}, {4{10'd1}}, 4'b0001);
        wait_done("h_vec_cleared_done", 20);

        repeat (5) tick();
        chk("sb_empty", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
